// File: rtl/seq_gates_1b_dff.sv
// Single-bit D flip-flop with asynchronous active-high reset.
// Used as a one-cycle delay or state bit by larger sequential blocks.
module seq_gates_1b_dff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_r;

  // Capture d on every rising edge; reset overrides asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: tb/tb_seq_gates_1b_dff.sv
// Directed and random self-checking bench for seq_gates_1b_dff.
// Inputs are driven 1 time unit after a rising edge and sampled away from edges.
module tb_seq_gates_1b_dff;

  logic clk;
  logic reset;
  logic d;
  logic q;
  logic q_set;
  logic prev_d;
  logic dv;
  int   tests_run;
  int   tests_failed;

  seq_gates_1b_dff dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  // Second instance confirms the reset value parameter is honoured.
  seq_gates_1b_dff #(.RESET_VALUE(1'b1)) dut_set (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q_set)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive dv after the edge, check q just after the edge and just before the next.
  task automatic drive_cycle(input logic dval, input logic exp_q, input string tag);
    @(posedge clk);
    #1;
    check_bit({tag, "_early"}, q, exp_q);
    d = dval;
    #7;
    check_bit({tag, "_late"}, q, exp_q);
  endtask

  initial begin
    logic rise_d [7];
    logic rise_q [7];
    logic alt_d  [5];
    logic alt_q  [5];
    tests_run    = 0;
    tests_failed = 0;
    rise_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rise_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    alt_d  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    alt_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with d=1: reset must dominate across clock edges.
    reset = 1'b1;
    d     = 1'b1;
    #1;
    check_bit("rst_async", q, 1'b0);
    check_bit("rst_async_set", q_set, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check_bit("rst_hold", q, 1'b0);
    check_bit("rst_hold_set", q_set, 1'b1);
    reset = 1'b0;
    d     = 1'b0;
    #6;
    check_bit("rst_release", q, 1'b0);
    check_bit("rst_release_set", q_set, 1'b1);

    // Reset then hold zero.
    drive_cycle(1'b0, 1'b0, "hold0");
    check_bit("hold0_set", q_set, 1'b0);
    drive_cycle(1'b0, 1'b0, "hold1");
    drive_cycle(1'b0, 1'b0, "hold2");

    // Rising transition, one-cycle delay.
    for (int i = 0; i < 7; i++) begin
      drive_cycle(rise_d[i], rise_q[i], $sformatf("rise%0d", i));
    end

    // Alternating data.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(alt_d[i], alt_q[i], $sformatf("alt%0d", i));
    end
    drive_cycle(1'b0, 1'b1, "alt_tail");

    // Mid-cycle d pulse must never reach q.
    @(posedge clk);
    #1;
    check_bit("mid_pre", q, 1'b0);
    d = 1'b1;
    #3;
    d = 1'b0;
    #3;
    check_bit("mid_during", q, 1'b0);
    @(posedge clk);
    #1;
    check_bit("mid_capture", q, 1'b0);
    #5;
    check_bit("mid_after", q, 1'b0);

    // Asynchronous reset mid-run with q=1.
    drive_cycle(1'b1, 1'b0, "arst_setup");
    @(posedge clk);
    #1;
    check_bit("arst_q1", q, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("arst_drop", q, 1'b0);
    @(posedge clk);
    #2;
    check_bit("arst_held", q, 1'b0);
    reset = 1'b0;
    d     = 1'b1;
    #5;
    check_bit("arst_wait", q, 1'b0);
    @(posedge clk);
    #1;
    check_bit("arst_resume", q, 1'b1);

    // Random: q follows the previous cycle's d.
    prev_d = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dv = 1'($urandom_range(1, 0));
      drive_cycle(dv, prev_d, $sformatf("rand%0d", i));
      prev_d = dv;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
